// File: rtl/icache_flush_ctrl.sv
// rtl/icache_flush_ctrl.sv - sequences a full refill of one icache memory block from backing memory
//
// Purpose:
//   On an accepted flush_req, takes over the memory block's flush port and
//   walks word indices 0..MEMSIZE-1. Each word is fetched from backing memory
//   with a req/ack read, then written into the block with a one-cycle strobe.
//
// Ports:
//   clk         in   system clock, all state on the rising edge
//   reset_n     in   asynchronous active-low reset
//   flush_req   in   start a flush (sampled only while idle)
//   base_addr   in   byte address of the memory image (bits [1:0] ignored)
//   busy        out  high from the accepting edge through the done cycle
//   done        out  one-cycle pulse after the last word is written
//   flush_mode  out  selects the memory block's flush port
//   flush_addr  out  current word index
//   flush_in    out  captured memory word (holds between writes)
//   flush_we    out  one-cycle write strobe into the memory block
//   mem_rd_req  out  read request to backing memory
//   mem_addr    out  read byte address, stable until mem_ack
//   mem_ack     in   read data valid / request accepted
//   mem_data    in   read data, valid with mem_ack

module icache_flush_ctrl #(
   parameter int DATABITS    = 32,
   parameter int ADDRBITS    = 5,
   parameter int MEMADDRBITS = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   flush_req,
   input  logic [MEMADDRBITS-1:0] base_addr,
   output logic                   busy,
   output logic                   done,
   output logic                   flush_mode,
   output logic [ADDRBITS-1:0]    flush_addr,
   output logic [DATABITS-1:0]    flush_in,
   output logic                   flush_we,
   output logic                   mem_rd_req,
   output logic [MEMADDRBITS-1:0] mem_addr,
   input  logic                   mem_ack,
   input  logic [DATABITS-1:0]    mem_data
);

   localparam int MEMSIZE = 2 ** ADDRBITS;
   localparam logic [ADDRBITS-1:0] LAST_IDX = ADDRBITS'(MEMSIZE - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]             state;
   logic [1:0]             state_nxt;
   logic [ADDRBITS-1:0]    idx;
   logic [MEMADDRBITS-1:0] base_q;
   logic [DATABITS-1:0]    word_q;

   // Next-state decode. flush_req is only looked at in IDLE, so a request
   // during a running flush (or in the DONE cycle) is dropped, not queued.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (flush_req) state_nxt = ST_REQ;
         ST_REQ:   if (mem_ack)   state_nxt = ST_WRITE;
         ST_WRITE: state_nxt = (idx == LAST_IDX) ? ST_DONE : ST_REQ;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_IDLE;
         idx    <= '0;
         base_q <= '0;
         word_q <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (flush_req) begin
                  // Word-align the image address once, at acceptance.
                  base_q <= base_addr & ~MEMADDRBITS'(3);
                  idx    <= '0;
               end
            end
            ST_REQ: begin
               // mem_ack is only meaningful here; elsewhere it is ignored.
               if (mem_ack) word_q <= mem_data;
            end
            ST_WRITE: begin
               if (idx != LAST_IDX) idx <= idx + ADDRBITS'(1);
            end
            default: ;
         endcase
      end
   end

   // Outputs decode straight from the state register so that an asynchronous
   // reset drops flush_mode and the strobes without waiting for a clock edge.
   always_comb begin
      busy       = 1'b0;
      done       = 1'b0;
      flush_mode = 1'b0;
      flush_we   = 1'b0;
      mem_rd_req = 1'b0;
      flush_addr = '0;
      mem_addr   = '0;
      case (state)
         ST_REQ: begin
            busy       = 1'b1;
            flush_mode = 1'b1;
            mem_rd_req = 1'b1;
            flush_addr = idx;
            // Byte address wraps modulo 2**MEMADDRBITS by plain truncation.
            mem_addr   = base_q + MEMADDRBITS'({idx, 2'b00});
         end
         ST_WRITE: begin
            busy       = 1'b1;
            flush_mode = 1'b1;
            flush_we   = 1'b1;
            flush_addr = idx;
         end
         ST_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   assign flush_in = word_q;

endmodule

// File: doc/icache_flush_ctrl.md
Name: icache_flush_ctrl

Overview:
- Sequences a full refill ("flush") of one icache memory block.
- On request, takes the block's port over with flush_mode and walks every word address 0..MEMSIZE-1.
- For each word: reads from backing memory through a req/ack handshake, then writes the word into the block via flush_addr/flush_in/flush_we.
- Sits between the icache memory block, the main-memory read port and the core's flush trigger.

Parameters:
- DATABITS, 32, width of a cache word and of mem_data.
- ADDRBITS, 5, cache word-address width; MEMSIZE=2**ADDRBITS words per flush.
- MEMADDRBITS, 32, byte-address width of the backing memory.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush_req  input  1  start a flush; sampled only in IDLE.
- base_addr  input  MEMADDRBITS  byte address of the memory image; latched on accepted flush_req; bits [1:0] forced to 0.
- busy  output  1  high from the accepting edge until done.
- done  output  1  one-cycle pulse when the last word is written.
- flush_mode  output  1  to memblock; selects the flush port.
- flush_addr  output  ADDRBITS  to memblock; current word index.
- flush_in  output  DATABITS  to memblock; captured memory word.
- flush_we  output  1  to memblock; one-cycle write strobe.
- mem_rd_req  output  1  read request to backing memory.
- mem_addr  output  MEMADDRBITS  read byte address.
- mem_ack  input  1  read data valid / request accepted.
- mem_data  input  DATABITS  read data, valid with mem_ack.

Behaviour:
- Reset (async, any state): state=IDLE, idx=0, all outputs 0, latched base=0.
- States: IDLE, REQ, WRITE, DONE.
- IDLE: all outputs 0. If flush_req=1: latch base_addr&~3, idx<=0, go to REQ.
- REQ:
  - busy=1, flush_mode=1, mem_rd_req=1, mem_addr=base+(idx<<2) modulo 2^MEMADDRBITS (wraps silently).
  - mem_rd_req and mem_addr stay stable until mem_ack.
  - On mem_ack=1 (including the first REQ cycle): capture mem_data into flush_in, go to WRITE.
- WRITE:
  - flush_we=1, flush_addr=idx, flush_in=captured word, flush_mode=1, mem_rd_req=0.
  - If idx==MEMSIZE-1: go to DONE; else idx<=idx+1, go to REQ.
- DONE: done=1, busy=1 for this cycle, flush_mode=0, flush_we=0; next state IDLE.
- flush_mode is 1 exactly in REQ and WRITE; flush_we is asserted only while flush_mode=1.
- flush_addr holds idx in REQ; it is valid in WRITE.
- flush_in holds its last value outside WRITE.
- flush_req outside IDLE is ignored, not queued; flush_req high in the DONE cycle is not accepted.
- Back-to-back: flush_req held high restarts a flush on the IDLE cycle after DONE.
- mem_ack outside REQ is ignored; no capture and no state change.
- Latency with zero-wait ack (ack in first REQ cycle):
  - 2 cycles per word.
  - done asserted 2*MEMSIZE+1 cycles after the accepting edge.
  - Each wait cycle on mem_ack adds 1 cycle.
- Reset mid-flush:
  - flush_mode drops immediately (async).
  - The partially refilled block is left as is; no resume.
- No timeout on mem_ack; the controller waits indefinitely in REQ.

Test Plan:
- Full flush, ack same cycle as req, base_addr=0x1000, mem_data=addr^0xA5A5A5A5 -> 32 writes, flush_addr 0..31, mem_addr 0x1000..0x107C step 4, done 65 cycles after accept, flush_mode=1 throughout.
- Ack delayed 3 cycles on word 5 -> mem_rd_req/mem_addr=0x1014 held stable 4 cycles, single flush_we for addr 5, done 3 cycles later than the zero-wait case.
- base_addr=0xFFFFFFC3 -> latched 0xFFFFFFC0, word 16 at mem_addr 0x00000000 (wrap), done after 32 writes.
- flush_req pulsed at cycles 10 and 40 of a running flush, plus stray mem_ack in IDLE -> no restart, no extra flush_we, idx sequence unbroken.
- reset_n low while in REQ at word 12 -> all outputs 0 immediately; after release, IDLE, and a new flush_req starts at idx 0.
- flush_req held high permanently -> done pulse, one IDLE cycle, new flush accepted, second flush identical to the first.
